// File: rtl/apb_master_arbiter_pkg.sv
// Shared definitions for the two-requester APB master front-end:
// FSM state encoding and the bus-error read-data pattern.
package apb_master_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_master_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that was not granted
// last time wins; a lone request always wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt
);

  assign gnt_valid = req0 | req1;
  assign gnt       = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master front-end: round-robin between M0 (CPU) and M1 (DMA), SETUP/ACCESS
// sequencing, per-requester read-data return and timeout abort with bus error.
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter int          TO_W     = 8,
  parameter logic [31:0] ERR_DATA = DEAD_BEEF
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        M0_REQ,
  input  logic [31:0] M0_ADDR,
  input  logic        M0_WRITE,
  input  logic [31:0] M0_WDATA,
  output logic        M0_ACK,
  output logic        M0_ERR,
  output logic [31:0] M0_RDATA,
  input  logic        M1_REQ,
  input  logic [31:0] M1_ADDR,
  input  logic        M1_WRITE,
  input  logic [31:0] M1_WDATA,
  output logic        M1_ACK,
  output logic        M1_ERR,
  output logic [31:0] M1_RDATA,
  output logic        PSEL,
  output logic        PENABLE,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  apb_state_e      state, next_state;
  logic            last;
  logic            owner;
  logic [TO_W-1:0] cnt;
  logic            err_q;
  logic [31:0]     rdata0, rdata1;
  logic            gnt_valid, gnt_id;
  logic            timeout_hit;
  logic [31:0]     cap_data;

  rr_arb2 u_arb (
    .req0      (M0_REQ),
    .req1      (M1_REQ),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt       (gnt_id)
  );

  // PREADY takes priority over a timeout landing in the same cycle.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LIMIT) && !PREADY;
  assign cap_data    = timeout_hit ? ERR_DATA : (PWRITE ? 32'h0 : PRDATA);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: default assignment first so no path leaves next_state unassigned
  // (which would infer a latch).
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (gnt_valid) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    PSEL    = (state == SETUP) || (state == ACCESS);
    PENABLE = (state == ACCESS);
    M0_ACK  = (state == RESP) && !owner;
    M1_ACK  = (state == RESP) &&  owner;
    M0_ERR  = M0_ACK && err_q;
    M1_ERR  = M1_ACK && err_q;
  end

  assign M0_RDATA = rdata0;
  assign M1_RDATA = rdata1;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      last   <= 1'b1;
      owner  <= 1'b0;
      cnt    <= '0;
      err_q  <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
    end else begin
      unique case (state)
        IDLE: if (gnt_valid) begin
          owner  <= gnt_id;
          last   <= gnt_id;
          cnt    <= '0;
          PADDR  <= gnt_id ? M1_ADDR  : M0_ADDR;
          PWRITE <= gnt_id ? M1_WRITE : M0_WRITE;
          PWDATA <= gnt_id ? M1_WDATA : M0_WDATA;
        end
        ACCESS: begin
          if (PREADY || timeout_hit) begin
            err_q <= timeout_hit;
            if (owner) rdata1 <= cap_data;
            else       rdata0 <= cap_data;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter (TIMEOUT=4).
module tb_apb_master_arbiter;

  logic        PCLK, PRESETn;
  logic        M0_REQ, M0_WRITE, M1_REQ, M1_WRITE;
  logic [31:0] M0_ADDR, M0_WDATA, M1_ADDR, M1_WDATA;
  logic        M0_ACK, M0_ERR, M1_ACK, M1_ERR;
  logic [31:0] M0_RDATA, M1_RDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY;
  logic [31:0] PADDR, PWDATA, PRDATA;

  int checks = 0;
  int errors = 0;

  apb_master_arbiter #(.TIMEOUT(4), .TO_W(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .M0_REQ(M0_REQ), .M0_ADDR(M0_ADDR), .M0_WRITE(M0_WRITE), .M0_WDATA(M0_WDATA),
    .M0_ACK(M0_ACK), .M0_ERR(M0_ERR), .M0_RDATA(M0_RDATA),
    .M1_REQ(M1_REQ), .M1_ADDR(M1_ADDR), .M1_WRITE(M1_WRITE), .M1_WDATA(M1_WDATA),
    .M1_ACK(M1_ACK), .M1_ERR(M1_ERR), .M1_RDATA(M1_RDATA),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    PRESETn = 1'b0;
    M0_REQ = 0; M0_WRITE = 0; M0_ADDR = 0; M0_WDATA = 0;
    M1_REQ = 0; M1_WRITE = 0; M1_ADDR = 0; M1_WDATA = 0;
    PREADY = 0; PRDATA = 0;
    #1;
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_ack", {M0_ACK, M1_ACK, M0_ERR, M1_ERR}, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_rdata0", M0_RDATA, 0);
    tick(); tick();
    PRESETn = 1'b1;

    // M0 write, zero wait states
    M0_REQ = 1; M0_ADDR = 32'h4000_0004; M0_WRITE = 1; M0_WDATA = 32'h1234_5678;
    PREADY = 1; PRDATA = 32'hFFFF_FFFF;
    tick();
    check("wr_setup_psel", {PSEL, PENABLE}, 32'b10);
    check("wr_paddr", PADDR, 32'h4000_0004);
    check("wr_pwrite", PWRITE, 1);
    check("wr_pwdata", PWDATA, 32'h1234_5678);
    tick();
    check("wr_access", {PSEL, PENABLE}, 32'b11);
    check("wr_no_ack_yet", M0_ACK, 0);
    tick();
    check("wr_resp", {PSEL, PENABLE, M0_ACK, M0_ERR, M1_ACK}, 32'b00100);
    check("wr_rdata_zero", M0_RDATA, 0);
    M0_REQ = 0;
    tick();
    check("wr_idle", {PSEL, M0_ACK}, 0);

    // M1 read, three wait states
    M1_REQ = 1; M1_ADDR = 32'h4000_1000; M1_WRITE = 0; PREADY = 0; PRDATA = 32'hA5A5_0001;
    tick();
    tick();
    check("rd_access_paddr", PADDR, 32'h4000_1000);
    check("rd_access_pwrite", PWRITE, 0);
    tick(); tick();
    check("rd_wait", {PSEL, PENABLE, M1_ACK}, 32'b110);
    tick();
    PREADY = 1;
    check("rd_cycle5_no_ack", M1_ACK, 0);
    tick();
    check("rd_ack", {M1_ACK, M1_ERR, M0_ACK}, 32'b100);
    check("rd_rdata", M1_RDATA, 32'hA5A5_0001);
    check("rd_m0_rdata_hold", M0_RDATA, 0);
    M1_REQ = 0;
    tick();

    // M0 read, PREADY stuck low -> timeout after TIMEOUT+1 ACCESS cycles
    M0_REQ = 1; M0_ADDR = 32'h4000_0008; M0_WRITE = 0; PREADY = 0; PRDATA = 32'h0000_1234;
    tick();
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("to_access5", {PENABLE, M0_ACK}, 32'b10);
    tick();
    check("to_ack_err", {M0_ACK, M0_ERR, PSEL}, 32'b110);
    check("to_rdata", M0_RDATA, 32'hDEAD_BEEF);
    M0_ADDR = 32'h4000_000C; PREADY = 1; PRDATA = 32'h0000_1111;
    tick();
    check("to_next_idle", {PSEL, M0_ACK}, 0);
    tick();
    check("to_next_paddr", PADDR, 32'h4000_000C);
    tick();
    tick();
    check("to_next_ack", {M0_ACK, M0_ERR}, 32'b10);
    check("to_next_rdata", M0_RDATA, 32'h0000_1111);
    M0_REQ = 0;
    tick();

    // M1 read, PREADY rises in the cycle the counter reaches TIMEOUT
    M1_REQ = 1; M1_ADDR = 32'h4000_1004; PREADY = 0; PRDATA = 32'hCAFE_0002;
    tick();
    tick();
    for (int i = 0; i < 4; i++) tick();
    PREADY = 1;
    tick();
    check("edge_ack", {M1_ACK, M1_ERR}, 32'b10);
    check("edge_rdata", M1_RDATA, 32'hCAFE_0002);
    check("edge_m0_hold", M0_RDATA, 32'h0000_1111);
    M1_REQ = 0;
    tick();

    // Async reset during ACCESS of an M0 transfer
    M0_REQ = 1; M0_ADDR = 32'h4000_0010; PREADY = 0;
    tick();
    tick();
    check("arst_pre", {PSEL, PENABLE}, 32'b11);
    PRESETn = 1'b0;
    #1;
    check("arst_drop", {PSEL, PENABLE, M0_ACK, M1_ACK}, 0);
    M0_REQ = 0;
    tick(); tick();
    PRESETn = 1'b1;

    // Both requesters held high: M0, M1, M0, M1
    M0_REQ = 1; M0_ADDR = 32'h0000_0010; M0_WRITE = 0;
    M1_REQ = 1; M1_ADDR = 32'h0000_0020; M1_WRITE = 0;
    PREADY = 1; PRDATA = 32'h0000_0077;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr%0d_paddr", k), PADDR, (k % 2 == 0) ? 32'h10 : 32'h20);
      tick();
      tick();
      check($sformatf("rr%0d_acks", k), {M1_ACK, M0_ACK}, (k % 2 == 0) ? 32'b01 : 32'b10);
      tick();
      check($sformatf("rr%0d_idle", k), {PSEL, M0_ACK, M1_ACK}, 0);
    end
    check("rr_rdata0", M0_RDATA, 32'h77);
    check("rr_rdata1", M1_RDATA, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
